seq_addsub: RTL

Parametrised multi-cycle two's-complement arithmetic unit that generalises the team's 20-bit complement and subtraction logic. It supports ADD, SUB, NEG and ones'-complement operations. It processes operands CHUNK bits per cycle behind valid/ready handshakes on both input and output. Its place in the design is between the operand register stage and the result writeback of the arithmetic datapath, where area matters more than single-cycle latency.

---
 rtl/arith_pkg.sv | 13 +
 rtl/seq_addsub_if.sv | 26 ++
 rtl/seq_addsub_chunk.sv | 27 ++
 rtl/seq_addsub.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Op encodings and FSM state constants shared by the arithmetic datapath blocks.
package arith_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NEG  = 2'b10;
  localparam logic [1:0] OP_CMPL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_addsub_if.sv
// Operand/result handshake bus of seq_addsub; master = producer/consumer side, slave = unit.
interface seq_addsub_if #(parameter int unsigned WIDTH = 20);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero
  );

endinterface

// File: rtl/seq_addsub_chunk.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its MSB for overflow detection.
module addsub_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      sum[i]   = x[i] ^ y[i] ^ w_c[i];
      w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
    cout  = w_c[CHUNK];
    c_msb = w_c[CHUNK-1];
  end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle ADD/SUB/NEG/CMPL unit, CHUNK bits per cycle behind valid/ready handshakes.
// Optional SEQ_ADDSUB_SAT_EN: saturate the result on signed overflow (ADD/SUB/NEG).
module seq_addsub
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_addsub_if.slave  bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  logic [1:0]       r_state, w_state_nxt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_x, r_y, r_result;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry, r_cout, r_ovf, r_zero;
  logic             r_in_ready, r_out_valid;

  logic             w_accept, w_last;
  logic [WIDTH-1:0] w_x_in, w_y_in;
  logic             w_cin;
  logic [31:0]      w_shift;
  logic [CHUNK-1:0] w_xc, w_yc, w_sum;
  logic             w_cout, w_c_msb;
  logic [WIDTH-1:0] w_res_nxt, w_final;
  logic             w_is_cmpl, w_ovf;

  assign w_accept  = (r_state == ST_IDLE) && bus.in_valid;
  assign w_last    = (r_idx == LAST_IDX);
  assign w_is_cmpl = (r_op == OP_CMPL);

  // Operand mapping: every op is x + y + cin
  always_comb begin
    w_x_in = bus.a;
    w_y_in = bus.b;
    w_cin  = 1'b0;
    case (bus.op)
      OP_SUB:  begin w_y_in = ~bus.b; w_cin = 1'b1; end
      OP_NEG:  begin w_x_in = '0; w_y_in = ~bus.a; w_cin = 1'b1; end
      OP_CMPL: begin w_x_in = '0; w_y_in = ~bus.a; end
      default: ;
    endcase
  end

  assign w_shift = 32'(r_idx) * CHUNK;
  assign w_xc    = CHUNK'(r_x >> w_shift);
  assign w_yc    = CHUNK'(r_y >> w_shift);

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x     (w_xc),
    .y     (w_yc),
    .cin   (r_carry),
    .sum   (w_sum),
    .cout  (w_cout),
    .c_msb (w_c_msb)
  );

  // Merge the new sum chunk into the partial result; on the last chunk this is the full result
  always_comb begin
    w_res_nxt = (r_result & ~(WIDTH'({CHUNK{1'b1}}) << w_shift))
              | (WIDTH'(w_sum) << w_shift);
    w_ovf     = (w_c_msb ^ w_cout) & ~w_is_cmpl;
    w_final   = w_res_nxt;
`ifdef SEQ_ADDSUB_SAT_EN
    // Wrapped MSB set means the true result was positive, and vice versa
    if (w_ovf) begin
      w_final = w_res_nxt[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                   : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)   w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)         w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready)  w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  // Datapath: latch on accept, one chunk per RUN cycle, flags on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_ADD;
      r_x      <= '0;
      r_y      <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_op    <= bus.op;
      r_x     <= w_x_in;
      r_y     <= w_y_in;
      r_carry <= w_cin;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_carry <= w_cout;
      if (w_last) begin
        r_idx    <= '0;
        r_result <= w_final;
        r_cout   <= w_cout & ~w_is_cmpl;
        r_ovf    <= w_ovf;
        r_zero   <= ~|w_final;
      end else begin
        r_idx    <= r_idx + IDXW'(1);
        r_result <= w_res_nxt;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

endmodule
